// File: rtl/range_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : range_counter_pkg
// Brief    : Shared mode encoding for the range_counter family.
// Revision : 1.0 - initial release
// ============================================================================
package range_counter_pkg;

    // Overflow/underflow policy selected by the 2-bit mode input.
    // MODE_RSVD is treated exactly like MODE_SAT.
    typedef enum logic [1:0] {
        MODE_SAT    = 2'b00,
        MODE_WRAP   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

endpackage : range_counter_pkg
`default_nettype wire

// File: rtl/range_counter_next.sv
`default_nettype none
// ============================================================================
// Module   : range_counter_next
// Brief    : Combinational next-count, event and bounce-flip computation for
//            range_counter. Out-of-range counts snap to the nearest bound;
//            in-range counts take one step, with the boundary policy applied
//            when the step would cross a bound.
// Config   : RANGE_COUNTER_BOUNCE_EN enables the BOUNCE policy; without it
//            mode 2'b10 falls through to saturation.
// Revision : 1.0 - initial release
// ============================================================================
module range_counter_next
    import range_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    output logic [WIDTH-1:0]  nxt,
    output logic              evt,
    output logic              flip
);

    localparam int c_PAD = WIDTH + 1 - STEP_W;

    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_lim;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf;
    logic             w_unf;

    // One extra bit so neither the sum nor the underflow limit can wrap.
    assign w_step = {{c_PAD{1'b0}}, step};
    assign w_sum  = {1'b0, count} + w_step;
    assign w_lim  = {1'b0, min_val} + w_step;
    assign w_diff = count - w_step[WIDTH-1:0];
    assign w_ovf  = dir & (w_sum > {1'b0, max_val});
    assign w_unf  = ~dir & ({1'b0, count} < w_lim);

    // Select next count: snap to bounds, hold on zero step, else step with policy.
    always_comb begin
        nxt  = count;
        evt  = 1'b0;
        flip = 1'b0;
        if (count < min_val) begin
            nxt = min_val;
        end else if (count > max_val) begin
            nxt = max_val;
        end else if (step != '0) begin
            if (w_ovf || w_unf) begin
                evt = 1'b1;
                case (mode)
                    MODE_WRAP: nxt = w_ovf ? min_val : max_val;
`ifdef RANGE_COUNTER_BOUNCE_EN
                    MODE_BOUNCE: begin
                        nxt  = w_ovf ? max_val : min_val;
                        flip = 1'b1;
                    end
`endif
                    default:   nxt = w_ovf ? max_val : min_val;
                endcase
            end else begin
                nxt = dir ? w_sum[WIDTH-1:0] : w_diff;
            end
        end
    end

endmodule : range_counter_next
`default_nettype wire

// File: rtl/range_counter.sv
`default_nettype none
// ============================================================================
// Module   : range_counter
// Brief    : Bounded up/down counter with saturate/wrap/bounce policies,
//            programmable step, clamped synchronous load and boundary flags.
// Config   : define RANGE_COUNTER_BOUNCE_EN to add the BOUNCE policy and its
//            direction register; otherwise cur_dir always follows dir.
// Revision : 1.0 - initial release
// ============================================================================
module range_counter
    import range_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    output logic [WIDTH-1:0]  count,
    output logic              at_min,
    output logic              at_max,
    output logic              evt,
    output logic              cur_dir,
    output logic              range_err
);

    logic [WIDTH-1:0] r_count;
    logic             r_evt;
    logic [WIDTH-1:0] w_nxt;
    logic             w_nxt_evt;
    logic             w_flip;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_eff_dir;
    logic             w_range_err;

    assign w_range_err    = min_val > max_val;
    assign w_load_clamped = (load_val < min_val) ? min_val :
                            (load_val > max_val) ? max_val : load_val;

`ifdef RANGE_COUNTER_BOUNCE_EN
    logic r_bdir;
    logic w_bounce;

    assign w_bounce  = (mode == MODE_BOUNCE);
    assign w_eff_dir = w_bounce ? r_bdir : dir;

    // Bounce direction: toggles on bounce events, tracks dir outside BOUNCE.
    always_ff @(posedge clk) begin
        if (rst)
            r_bdir <= 1'b1;
        else if (load || !w_bounce)
            r_bdir <= dir;
        else if (!w_range_err && en && w_flip)
            r_bdir <= ~r_bdir;
    end
`else
    assign w_eff_dir = dir;
`endif

    range_counter_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .count   (r_count),
        .dir     (w_eff_dir),
        .mode    (mode),
        .step    (step),
        .min_val (min_val),
        .max_val (max_val),
        .nxt     (w_nxt),
        .evt     (w_nxt_evt),
        .flip    (w_flip)
    );

    // Count and event register with rst > load > range_err hold > en priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= min_val;
            r_evt   <= 1'b0;
        end else if (load) begin
            r_count <= w_range_err ? load_val : w_load_clamped;
            r_evt   <= 1'b0;
        end else if (!w_range_err && en) begin
            r_count <= w_nxt;
            r_evt   <= w_nxt_evt;
        end else begin
            r_evt   <= 1'b0;
        end
    end

    assign count     = r_count;
    assign evt       = r_evt;
    assign at_min    = (r_count == min_val);
    assign at_max    = (r_count == max_val);
    assign cur_dir   = w_eff_dir;
    assign range_err = w_range_err;

endmodule : range_counter
`default_nettype wire

// File: tb/tb_range_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_counter
// Brief    : Table-driven self-checking bench for range_counter (WIDTH=4).
//            Each vector is held across one rising edge; outputs are sampled
//            1 time unit later with the same inputs still applied.
// Config   : expectations follow RANGE_COUNTER_BOUNCE_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_counter;
    import range_counter_pkg::*;

    localparam int c_W = 4;
    localparam int c_S = 4;

    logic           clk = 1'b0;
    logic           rst, en, dir, load;
    logic [1:0]     mode;
    logic [c_S-1:0] step;
    logic [c_W-1:0] load_val, min_val, max_val;
    logic [c_W-1:0] count;
    logic           at_min, at_max, evt, cur_dir, range_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic           rst, load, en, dir;
        logic [1:0]     mode;
        logic [c_S-1:0] step;
        logic [c_W-1:0] lv, mn, mx;
        logic [c_W-1:0] e_count;
        logic           e_evt, e_amin, e_amax, e_cdir, e_rerr;
    } vec_t;

    vec_t vecs[$];

    range_counter #(.WIDTH(c_W), .STEP_W(c_S)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .mode      (mode),
        .step      (step),
        .load      (load),
        .load_val  (load_val),
        .min_val   (min_val),
        .max_val   (max_val),
        .count     (count),
        .at_min    (at_min),
        .at_max    (at_max),
        .evt       (evt),
        .cur_dir   (cur_dir),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic l, input logic e, input logic d,
                       input logic [1:0] m, input int s, input int lv, input int mn,
                       input int mx, input int ec, input logic ee, input logic ea0,
                       input logic ea1, input logic ecd, input logic er);
        vec_t v;
        v.rst = r; v.load = l; v.en = e; v.dir = d; v.mode = m;
        v.step = c_S'(s); v.lv = c_W'(lv); v.mn = c_W'(mn); v.mx = c_W'(mx);
        v.e_count = c_W'(ec); v.e_evt = ee; v.e_amin = ea0; v.e_amax = ea1;
        v.e_cdir = ecd; v.e_rerr = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst = v.rst; load = v.load; en = v.en; dir = v.dir; mode = v.mode;
        step = v.step; load_val = v.lv; min_val = v.mn; max_val = v.mx;
        @(posedge clk);
        #1;
        check($sformatf("v%0d count", idx),     int'(count),     int'(v.e_count));
        check($sformatf("v%0d evt", idx),       int'(evt),       int'(v.e_evt));
        check($sformatf("v%0d at_min", idx),    int'(at_min),    int'(v.e_amin));
        check($sformatf("v%0d at_max", idx),    int'(at_max),    int'(v.e_amax));
        check($sformatf("v%0d cur_dir", idx),   int'(cur_dir),   int'(v.e_cdir));
        check($sformatf("v%0d range_err", idx), int'(range_err), int'(v.e_rerr));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b1; mode = 2'b00;
        step = '0; load_val = '0; min_val = 4'd3; max_val = 4'd12;

        //   rst load en dir mode        step lv mn mx | cnt evt amin amax cdir rerr
        add(1, 0, 0, 1, MODE_SAT,    0,  0, 3, 12,   3, 0, 1, 0, 1, 0); // reset
        add(0, 1, 1, 1, MODE_SAT,    4, 10, 3, 12,  10, 0, 0, 0, 1, 0); // load 10
        add(0, 0, 1, 1, MODE_SAT,    4,  0, 3, 12,  12, 1, 0, 1, 1, 0); // sat
        add(0, 0, 1, 1, MODE_SAT,    4,  0, 3, 12,  12, 1, 0, 1, 1, 0); // sat again
        add(0, 0, 0, 1, MODE_SAT,    4,  0, 3, 12,  12, 0, 0, 1, 1, 0); // en=0
        add(0, 1, 0, 0, MODE_WRAP,   2,  4, 3, 12,   4, 0, 0, 0, 0, 0); // load 4
        add(0, 0, 1, 0, MODE_WRAP,   2,  0, 3, 12,  12, 1, 0, 1, 0, 0); // wrap down
        add(0, 0, 1, 0, MODE_WRAP,   2,  0, 3, 12,  10, 0, 0, 0, 0, 0); // step down
        add(0, 0, 1, 0, MODE_WRAP,   0,  0, 3, 12,  10, 0, 0, 0, 0, 0); // step=0
        add(0, 1, 1, 1, MODE_SAT,    1, 15, 2,  9,   9, 0, 0, 1, 1, 0); // load clamp hi
        add(0, 1, 1, 1, MODE_SAT,    1,  0, 2,  9,   2, 0, 1, 0, 1, 0); // load clamp lo
        add(0, 0, 1, 1, MODE_SAT,    1,  0, 9,  4,   2, 0, 0, 0, 1, 1); // range_err hold
        add(0, 1, 0, 1, MODE_SAT,    1, 15, 9,  4,  15, 0, 0, 0, 1, 1); // unclamped load
        add(1, 1, 1, 1, MODE_SAT,    1,  5, 3, 12,   3, 0, 1, 0, 1, 0); // rst beats load
        add(0, 0, 1, 1, MODE_SAT,    1,  0, 6, 12,   6, 0, 1, 0, 1, 0); // below min snap
        add(0, 0, 1, 0, MODE_WRAP,   1,  0, 0,  4,   4, 0, 0, 1, 0, 0); // above max snap
        // Bounce sequence: step 3 in [0,7] starting from reset at 0.
        add(1, 0, 0, 1, MODE_BOUNCE, 3,  0, 0,  7,   0, 0, 1, 0, 1, 0);
`ifdef RANGE_COUNTER_BOUNCE_EN
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   3, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   6, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   7, 1, 0, 1, 0, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   4, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   3, 0, 0, 0, 1, 0);
        // Leave BOUNCE: register reloads from dir=0, then re-enter with en=0.
        add(0, 0, 1, 0, MODE_SAT,    3,  0, 0,  7,   0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, MODE_BOUNCE, 3,  0, 0,  7,   0, 0, 1, 0, 0, 0);
`else
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   3, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   6, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   7, 1, 0, 1, 1, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   7, 1, 0, 1, 1, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   7, 1, 0, 1, 1, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   7, 1, 0, 1, 1, 0);
        add(0, 0, 1, 1, MODE_BOUNCE, 3,  0, 0,  7,   7, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, MODE_SAT,    3,  0, 0,  7,   4, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, MODE_BOUNCE, 3,  0, 0,  7,   4, 0, 0, 0, 1, 0);
`endif

        foreach (vecs[i]) apply(vecs[i], i);

        // Hand sequence: SAT held at max with en=1 keeps evt continuously high
        // (reserved mode 11 must behave the same), then mid-run reset.
        rst = 1'b0; load = 1'b1; en = 1'b0; dir = 1'b1; mode = MODE_RSVD;
        step = 4'd5; load_val = 4'd8; min_val = 4'd1; max_val = 4'd10;
        @(posedge clk); #1;
        check("seq load", int'(count), 8);
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("seq sat%0d count", k), int'(count), 10);
            check($sformatf("seq sat%0d evt", k),   int'(evt),   1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("seq reset count", int'(count), 1);
        check("seq reset evt",   int'(evt),   0);
        rst = 1'b0; mode = MODE_WRAP; dir = 1'b0; step = 4'd1;
        @(posedge clk); #1;
        check("seq wrap from min", int'(count), 10);
        check("seq wrap evt",      int'(evt),   1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_range_counter
`default_nettype wire
